// File: rtl/sift_pkg.sv
// Shared constants, entry layouts and small helpers for the keypoint read path.
package sift_pkg;

    localparam int ADDR_W   = 11;
    localparam int ROW_W    = 9;
    localparam int COL_W    = 10;
    localparam int IMG_ROWS = 480;
    localparam int IMG_COLS = 640;

    localparam int ENTRY_W  = ROW_W + COL_W;
    localparam int STREAM_W = ENTRY_W + 2;

    localparam logic [ADDR_W:0]   MAX_COUNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ROW_W-1:0]  ROW_LIMIT = ROW_W'(IMG_ROWS);
    localparam logic [COL_W-1:0]  COL_LIMIT = COL_W'(IMG_COLS);

    // Row occupies the upper bits of the SRAM word, column the lower bits.
    typedef struct packed {
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
    } kp_entry_t;

    typedef struct packed {
        logic             layer;
        logic             last;
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
    } stream_entry_t;

    function automatic logic [ADDR_W:0] clamp_count(input logic [ADDR_W:0] c);
        return (c > MAX_COUNT) ? MAX_COUNT : c;
    endfunction

    function automatic logic entry_out_of_range(input kp_entry_t e);
        return (e.row >= ROW_LIMIT) || (e.col >= COL_LIMIT);
    endfunction

endpackage

// File: rtl/keypoint_stream_reader_if.sv
// Valid/ready keypoint stream toward the descriptor stage.
interface keypoint_stream_reader_if;

    logic                       kp_valid;
    logic                       kp_ready;
    logic [sift_pkg::ROW_W-1:0] kp_row;
    logic [sift_pkg::COL_W-1:0] kp_col;
    logic                       kp_layer;
    logic                       kp_last;

    modport master (
        output kp_valid, kp_row, kp_col, kp_layer, kp_last,
        input  kp_ready
    );

    modport slave (
        input  kp_valid, kp_row, kp_col, kp_layer, kp_last,
        output kp_ready
    );

endinterface

// File: rtl/keypoint_skid_fifo.sv
// Two-entry FIFO absorbing SRAM read latency and downstream stalls.
module keypoint_skid_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = push ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d = pop  ? ~rd_ptr_q : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
        logic [WIDTH-1:0] slot_q, slot_d;

        always_comb begin
            slot_d = slot_q;
            if (push && (wr_ptr_q == 1'(gi)))
                slot_d = push_data;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                slot_q <= '0;
            else
                slot_q <= slot_d;
        end
    end

    // A push into the slot under the read pointer only happens when empty
    // or together with a pop, so the presented head never changes while stalled.
    assign head_data = rd_ptr_q ? g_slot[1].slot_q : g_slot[0].slot_q;
    assign full      = (count_q == 2'd2);
    assign empty     = (count_q == 2'd0);

endmodule

// File: rtl/keypoint_stream_reader.sv
// Walks both keypoint SRAMs after a detection pass and streams their {row, col}
// entries downstream, SRAM 1 first, then SRAM 2.
module keypoint_stream_reader
    import sift_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [ADDR_W:0]          kp1_count,
    input  logic [ADDR_W:0]          kp2_count,
    output logic [ADDR_W-1:0]        keypoint_1_addr,
    input  logic [ENTRY_W-1:0]       keypoint_1_dout,
    output logic [ADDR_W-1:0]        keypoint_2_addr,
    input  logic [ENTRY_W-1:0]       keypoint_2_dout,
    keypoint_stream_reader_if.master kp_if,
    output logic                     busy,
    output logic                     done,
    output logic                     range_err
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RD1   = 3'd1;
    localparam logic [2:0] ST_RD2   = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_FIN   = 3'd4;

    localparam logic [ADDR_W:0]   IDX_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W:0]   cnt1_q, cnt1_d, cnt2_q, cnt2_d;
    logic [ADDR_W-1:0] addr1_q, addr1_d, addr2_q, addr2_d;
    logic              iss_q, iss_d;
    logic              iss_layer_q, iss_layer_d;
    logic              iss_last_q, iss_last_d;
    logic              range_err_q, range_err_d;

    logic              fifo_full, fifo_empty;
    logic              can_issue, fire, last1, last2;
    logic [STREAM_W-1:0] head_bits;
    kp_entry_t         rd_entry;
    stream_entry_t     push_entry, head_entry;

    // At most two entries may be buffered or in flight, so the FIFO never overflows.
    assign can_issue  = !fifo_full && (fifo_empty || !iss_q);
    assign fire       = !fifo_empty && kp_if.kp_ready;
    assign rd_entry   = iss_layer_q ? kp_entry_t'(keypoint_2_dout) : kp_entry_t'(keypoint_1_dout);
    assign push_entry = '{layer: iss_layer_q, last: iss_last_q, row: rd_entry.row, col: rd_entry.col};
    assign head_entry = stream_entry_t'(head_bits);
    assign last1      = (({1'b0, addr1_q} + IDX_ONE) == cnt1_q);
    assign last2      = (({1'b0, addr2_q} + IDX_ONE) == cnt2_q);

    always_comb begin
        state_d     = state_q;
        cnt1_d      = cnt1_q;
        cnt2_d      = cnt2_q;
        addr1_d     = addr1_q;
        addr2_d     = addr2_q;
        iss_d       = 1'b0;
        iss_layer_d = iss_layer_q;
        iss_last_d  = 1'b0;
        range_err_d = range_err_q;

        if (iss_q && entry_out_of_range(rd_entry))
            range_err_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cnt1_d      = clamp_count(kp1_count);
                    cnt2_d      = clamp_count(kp2_count);
                    range_err_d = 1'b0;
                    if (cnt1_d != '0)
                        state_d = ST_RD1;
                    else if (cnt2_d != '0)
                        state_d = ST_RD2;
                    else
                        state_d = ST_FIN;
                end
            end
            ST_RD1: begin
                if (can_issue) begin
                    iss_d       = 1'b1;
                    iss_layer_d = 1'b0;
                    iss_last_d  = last1 && (cnt2_q == '0);
                    addr1_d     = addr1_q + ADDR_ONE;
                    if (last1)
                        state_d = (cnt2_q != '0) ? ST_RD2 : ST_DRAIN;
                end
            end
            ST_RD2: begin
                if (can_issue) begin
                    iss_d       = 1'b1;
                    iss_layer_d = 1'b1;
                    iss_last_d  = last2;
                    addr2_d     = addr2_q + ADDR_ONE;
                    if (last2)
                        state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // The tagged entry is the final one issued, so its transfer implies
                // nothing is left in flight or buffered.
                if (fire && head_entry.last)
                    state_d = ST_FIN;
            end
            ST_FIN: begin
                state_d = ST_IDLE;
                addr1_d = '0;
                addr2_d = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt1_q      <= '0;
            cnt2_q      <= '0;
            addr1_q     <= '0;
            addr2_q     <= '0;
            iss_q       <= 1'b0;
            iss_layer_q <= 1'b0;
            iss_last_q  <= 1'b0;
            range_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt1_q      <= cnt1_d;
            cnt2_q      <= cnt2_d;
            addr1_q     <= addr1_d;
            addr2_q     <= addr2_d;
            iss_q       <= iss_d;
            iss_layer_q <= iss_layer_d;
            iss_last_q  <= iss_last_d;
            range_err_q <= range_err_d;
        end
    end

    keypoint_skid_fifo #(
        .WIDTH (STREAM_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (iss_q),
        .push_data (push_entry),
        .pop       (fire),
        .head_data (head_bits),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign keypoint_1_addr = addr1_q;
    assign keypoint_2_addr = addr2_q;
    assign kp_if.kp_valid  = !fifo_empty;
    assign kp_if.kp_row    = head_entry.row;
    assign kp_if.kp_col    = head_entry.col;
    assign kp_if.kp_layer  = head_entry.layer;
    assign kp_if.kp_last   = head_entry.last;
    assign busy            = (state_q != ST_IDLE);
    assign done            = (state_q == ST_FIN);
    assign range_err       = range_err_q;

endmodule

// File: tb/tb_keypoint_stream_reader.sv
// Scoreboard bench: stimulus queues the expected stream, a negedge monitor checks it.
module tb_keypoint_stream_reader;
    import sift_pkg::*;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic [ADDR_W:0]     kp1_count = '0;
    logic [ADDR_W:0]     kp2_count = '0;
    logic [ADDR_W-1:0]   a1, a2;
    logic [ENTRY_W-1:0]  d1, d2;
    logic                busy, done, range_err;

    keypoint_stream_reader_if kp_if();

    keypoint_stream_reader dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .kp1_count       (kp1_count),
        .kp2_count       (kp2_count),
        .keypoint_1_addr (a1),
        .keypoint_1_dout (d1),
        .keypoint_2_addr (a2),
        .keypoint_2_dout (d2),
        .kp_if           (kp_if),
        .busy            (busy),
        .done            (done),
        .range_err       (range_err)
    );

    always #5 clk = ~clk;

    logic [ENTRY_W-1:0] mem1 [2048];
    logic [ENTRY_W-1:0] mem2 [2048];

    always @(posedge clk) begin
        d1 <= mem1[a1];
        d2 <= mem2[a2];
    end

    stream_entry_t exp_q[$];
    int  errors = 0;
    int  checks = 0;
    int  ready_mode = 0;
    int  xfers = 0;
    bit  run_zero = 1'b0;
    bit  exp_range = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [ENTRY_W-1:0] mk(input int r, input int c);
        logic [ROW_W-1:0] rr;
        logic [COL_W-1:0] cc;
        rr = ROW_W'(r);
        cc = COL_W'(c);
        return {rr, cc};
    endfunction

    // Ready pattern generator
    initial begin
        int cyc = 0;
        kp_if.kp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       kp_if.kp_ready = 1'b1;
                1:       kp_if.kp_ready = (cyc % 3 == 0);
                default: kp_if.kp_ready = 1'($urandom_range(0, 1));
            endcase
            cyc++;
        end
    end

    // Monitor / scoreboard
    initial begin
        bit            prev_stall = 1'b0;
        bit            done_exp = 1'b0;
        bit            next_done;
        stream_entry_t prev_out = '0;
        stream_entry_t cur, expd;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
                done_exp   = 1'b0;
            end else begin
                cur = '{layer: kp_if.kp_layer, last: kp_if.kp_last, row: kp_if.kp_row, col: kp_if.kp_col};
                if (done || done_exp)
                    check("done_pulse", 32'(done), 32'(done_exp));
                if (prev_stall) begin
                    check("stall_valid", 32'(kp_if.kp_valid), 32'd1);
                    check("stall_hold", 32'(cur), 32'(prev_out));
                end
                next_done = start && run_zero;
                if (kp_if.kp_valid && kp_if.kp_ready) begin
                    xfers++;
                    $display("xfer %0d layer=%0d row=%0d col=%0d last=%0d",
                             xfers, cur.layer, cur.row, cur.col, cur.last);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_xfer actual=%0h required=none", 32'(cur));
                    end else begin
                        expd = exp_q.pop_front();
                        check("xfer_entry", 32'(cur), 32'(expd));
                    end
                    if (cur.last)
                        next_done = 1'b1;
                end
                prev_stall = kp_if.kp_valid && !kp_if.kp_ready;
                prev_out   = cur;
                done_exp   = next_done;
            end
        end
    end

    task automatic fill_random(input int bad_pct);
        for (int i = 0; i < 2048; i++) begin
            mem1[i] = ($urandom_range(0, 99) < bad_pct) ? ENTRY_W'($urandom)
                                                        : mk($urandom_range(0, 479), $urandom_range(0, 639));
            mem2[i] = mk($urandom_range(0, 479), $urandom_range(0, 639));
        end
    endtask

    // Address-coded contents make every entry unique per address.
    task automatic fill_coded();
        for (int i = 0; i < 2048; i++) begin
            mem1[i] = {ADDR_W'(i), 8'($urandom)};
            mem2[i] = {~ADDR_W'(i), 8'($urandom)};
        end
    endtask

    task automatic prepare(input int k1, input int k2);
        int        e1, e2;
        kp_entry_t ent;
        e1 = (k1 > 2048) ? 2048 : k1;
        e2 = (k2 > 2048) ? 2048 : k2;
        exp_range = 1'b0;
        for (int i = 0; i < e1; i++) begin
            ent = mem1[i];
            exp_q.push_back('{layer: 1'b0, last: (i == e1 - 1) && (e2 == 0), row: ent.row, col: ent.col});
            if (int'(ent.row) >= IMG_ROWS || int'(ent.col) >= IMG_COLS) exp_range = 1'b1;
        end
        for (int j = 0; j < e2; j++) begin
            ent = mem2[j];
            exp_q.push_back('{layer: 1'b1, last: (j == e2 - 1), row: ent.row, col: ent.col});
            if (int'(ent.row) >= IMG_ROWS || int'(ent.col) >= IMG_COLS) exp_range = 1'b1;
        end
        run_zero = (e1 == 0) && (e2 == 0);
    endtask

    task automatic pulse_start(input int k1, input int k2);
        @(posedge clk);
        #1;
        kp1_count = (ADDR_W+1)'(k1);
        kp2_count = (ADDR_W+1)'(k2);
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        kp1_count = (ADDR_W+1)'($urandom);
        kp2_count = (ADDR_W+1)'($urandom);
    endtask

    task automatic run_case(input int k1, input int k2, input int rmode, input bit bogus, input int thr);
        int n = 0;
        bit got = 1'b0;
        ready_mode = rmode;
        prepare(k1, k2);
        pulse_start(k1, k2);
        while (!got && n < 20000) begin
            @(negedge clk);
            if (n == 0) begin
                check("range_err_clear", 32'(range_err), 32'd0);
                check("busy_after_start", 32'(busy), 32'd1);
            end
            start = bogus && (n == 4);
            if (done) got = 1'b1;
            n++;
        end
        start = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=no_done required=done k1=%0d k2=%0d", k1, k2);
        end else begin
            check("range_err", 32'(range_err), 32'(exp_range));
            check("queue_drained", 32'(exp_q.size()), 32'd0);
            if (thr > 0)
                check("throughput", 32'(n <= thr), 32'd1);
        end
        exp_q.delete();
        @(negedge clk);
        check("busy_idle", 32'(busy), 32'd0);
        check("addr1_idle", 32'(a1), 32'd0);
    endtask

    initial begin
        int n;
        #1;
        check("rst_valid", 32'(kp_if.kp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_range_err", 32'(range_err), 32'd0);
        check("rst_addr2", 32'(a2), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed data set
        fill_random(0);
        mem1[0] = mk(5, 7);
        mem1[1] = mk(5, 9);
        mem1[2] = mk(6, 100);
        mem2[0] = mk(10, 1);
        mem2[1] = mk(479, 639);
        run_case(3, 2, 0, 1'b0, 0);
        run_case(3, 2, 1, 1'b1, 0);
        run_case(0, 0, 0, 1'b0, 0);
        run_case(0, 1, 2, 1'b0, 0);

        // Out-of-range entry, sticky until the next start
        mem1[0] = mk(480, 0);
        run_case(2, 0, 0, 1'b0, 0);
        repeat (5) @(negedge clk);
        check("range_err_sticky", 32'(range_err), 32'd1);
        mem1[0] = mk(5, 7);
        run_case(3, 2, 0, 1'b0, 0);

        // Full-size readout and count clamping
        fill_coded();
        run_case(2048, 2048, 0, 1'b0, 8200);
        run_case(4000, 0, 2, 1'b0, 0);

        // Random runs
        for (int r = 0; r < 6; r++) begin
            fill_random(10);
            run_case($urandom_range(0, 40), $urandom_range(0, 40), 2, 1'($urandom_range(0, 1)), 0);
        end

        // Reset in the middle of reading SRAM 2
        fill_random(0);
        ready_mode = 1;
        prepare(4, 200);
        pulse_start(4, 200);
        n = 0;
        while (int'(a2) < 5 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("reached_rd2", 32'(int'(a2) >= 5), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("mid_rst_valid", 32'(kp_if.kp_valid), 32'd0);
        check("mid_rst_last", 32'(kp_if.kp_last), 32'd0);
        check("mid_rst_row", 32'(kp_if.kp_row), 32'd0);
        check("mid_rst_col", 32'(kp_if.kp_col), 32'd0);
        check("mid_rst_layer", 32'(kp_if.kp_layer), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_range_err", 32'(range_err), 32'd0);
        check("mid_rst_addr1", 32'(a1), 32'd0);
        check("mid_rst_addr2", 32'(a2), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        run_case(4, 200, 2, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
